// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong scoring controller.
//   state_t   - game-flow states
//   SCORE_W   - score width in bits
//   SEG_TABLE - active-low seven-segment patterns for digits 0..9, seg[0] = a
package pong_pkg;
    localparam int SCORE_W = 4;
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    function automatic logic [6:0] segOf(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction
endpackage

// File: rtl/pong_score_ctrl_if.sv
// pong_score_ctrl_if: game-side signals of the scoring controller.
//   master - drives start/frame_tick/hit1/hit2, observes the controller outputs
//   slave  - the controller itself
interface pong_score_ctrl_if;
    import pong_pkg::*;
    logic start;
    logic frame_tick;
    logic hit1;
    logic hit2;
    logic still;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic game_over;
    logic winner;
    logic [3:0] an;
    logic [6:0] seg;
    modport master (
        output start, frame_tick, hit1, hit2,
        input  still, score1, score2, game_over, winner, an, seg
    );
    modport slave (
        input  start, frame_tick, hit1, hit2,
        output still, score1, score2, game_over, winner, an, seg
    );
endinterface

// File: rtl/pong_sevseg.sv
// pong_sevseg: multiplexed 4-digit seven-segment score display.
//   clk, reset     - clock, synchronous active-high reset
//   score1, score2 - binary scores; shown as tens/ones on digits 3,2 and 1,0
//   an             - active-low digit enables, one low at a time after reset
//   seg            - active-low segments a..g on seg[0]..seg[6]
module pong_sevseg
    import pong_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    output logic [3:0]         an,
    output logic [6:0]         seg
);
    logic [SCAN_DIV+1:0] scanCnt;
    logic [1:0]          sel;
    logic [3:0]          digit;

    assign sel = scanCnt[SCAN_DIV+1 -: 2];

    always_comb
        digit = sel == 2'd3 ? score1 / 4'd10 :
                sel == 2'd2 ? score1 % 4'd10 :
                sel == 2'd1 ? score2 / 4'd10 : score2 % 4'd10;

    always_ff @(posedge clk)
        if (reset) begin
            scanCnt <= '0;
            an      <= 4'hF;
            seg     <= 7'h7F;
        end else begin
            scanCnt <= scanCnt + 1'b1;
            an      <= ~(4'b0001 << sel);
            seg     <= segOf(digit);
        end
endmodule

// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: game-flow and scoring controller for pong.
//   clk, reset  - clock, synchronous active-high reset
//   bus (slave) - start, frame_tick, hit1, hit2 in; still, score1, score2,
//                 game_over, winner, an, seg out
// Optional display: define PONG_SEVSEG_EN to build the seven-segment scanner;
// otherwise an/seg are held blank.
module pong_score_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 90,
    parameter int SCAN_DIV     = 16
) (
    input logic clk,
    input logic reset,
    pong_score_ctrl_if.slave bus
);
    localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         LastServe = 8'(SERVE_FRAMES - 1);

    state_t             state, nextState;
    logic               startQ;
    logic               startRise;
    logic               pointTo;
    logic [7:0]         serveCnt;
    logic [SCORE_W-1:0] newScore;

    // startQ resets high so a button held through reset is not a press
    assign startRise = bus.start & ~startQ;
    // pointTo: 1 = point credited to player 2
    assign newScore  = (pointTo ? bus.score2 : bus.score1) + 1'b1;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = startRise ? SERVE : IDLE;
            SERVE:   nextState = (bus.frame_tick && serveCnt == LastServe) ? PLAY : SERVE;
            PLAY:    nextState = (bus.hit1 || bus.hit2) ? POINT : PLAY;
            POINT:   nextState = newScore == WinScore ? OVER : SERVE;
            OVER:    nextState = startRise ? SERVE : OVER;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) begin
            state         <= IDLE;
            startQ        <= 1'b1;
            serveCnt      <= '0;
            pointTo       <= 1'b0;
            bus.still     <= 1'b1;
            bus.game_over <= 1'b0;
            bus.winner    <= 1'b0;
            bus.score1    <= '0;
            bus.score2    <= '0;
        end else begin
            state         <= nextState;
            startQ        <= bus.start;
            bus.still     <= nextState != PLAY;
            bus.game_over <= nextState == OVER;
            // held at zero outside SERVE, so every serve starts from a clean count
            if (state != SERVE)
                serveCnt <= '0;
            else if (bus.frame_tick)
                serveCnt <= serveCnt + 1'b1;
            // hit1 takes priority when both sides miss together
            if (state == PLAY)
                pointTo <= bus.hit1;
            if (state == POINT) begin
                if (pointTo)
                    bus.score2 <= newScore;
                else
                    bus.score1 <= newScore;
                if (nextState == OVER)
                    bus.winner <= pointTo;
            end
            if (state == OVER && startRise) begin
                bus.score1 <= '0;
                bus.score2 <= '0;
            end
        end

`ifdef PONG_SEVSEG_EN
    pong_sevseg #(.SCAN_DIV(SCAN_DIV)) u_sevseg (
        .clk    (clk),
        .reset  (reset),
        .score1 (bus.score1),
        .score2 (bus.score2),
        .an     (bus.an),
        .seg    (bus.seg)
    );
`else
    logic unusedScanDiv;
    assign unusedScanDiv = ^SCAN_DIV;
    assign bus.an  = 4'hF;
    assign bus.seg = 7'h7F;
`endif
endmodule

// File: tb/tb_pong_score_ctrl.sv
// tb_pong_score_ctrl: directed vector table, display scan check and randomized
// play against a behavioural game model.
module tb_pong_score_ctrl;
    import pong_pkg::*;

    localparam int WIN = 2;
    localparam int SF  = 3;
    localparam int SD  = 2;

    typedef struct {
        logic [4:0]  in;   // reset, start, frame_tick, hit1, hit2
        logic [10:0] exp;  // still, score1, score2, game_over, winner
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_score_ctrl_if bus();

    pong_score_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // behavioural model: mode 0 idle, 1 serving, 2 playing, 3 scoring, 4 over
    int mMode, mCnt, mS1, mS2, mPt;
    bit mWin, mPrev;

    task automatic modelStep(input bit r, s, f, a, b);
        bit rise;
        int ns;
        if (r) begin
            mMode = 0; mCnt = 0; mS1 = 0; mS2 = 0; mPt = 0; mWin = 0; mPrev = 1;
        end else begin
            rise  = s && !mPrev;
            mPrev = s;
            case (mMode)
                0: if (rise) begin mMode = 1; mCnt = 0; end
                1: if (f) begin
                       if (mCnt == SF - 1) mMode = 2;
                       else mCnt++;
                   end
                2: if (a) begin mMode = 3; mPt = 2; end
                   else if (b) begin mMode = 3; mPt = 1; end
                3: begin
                       if (mPt == 1) begin mS1++; ns = mS1; end
                       else begin mS2++; ns = mS2; end
                       if (ns == WIN) begin mMode = 4; mWin = (mPt == 2); end
                       else begin mMode = 1; mCnt = 0; end
                   end
                default: if (rise) begin mMode = 1; mCnt = 0; mS1 = 0; mS2 = 0; end
            endcase
        end
    endtask

    task automatic step(input bit r, s, f, a, b);
        reset = r; bus.start = s; bus.frame_tick = f; bus.hit1 = a; bus.hit2 = b;
        @(posedge clk);
        #1;
        modelStep(r, s, f, a, b);
    endtask

    task automatic checkOut(input string name, input logic [10:0] exp);
        logic [10:0] act;
        bit bad;
        act = {bus.still, bus.score1, bus.score2, bus.game_over, bus.winner};
        bad = act !== exp;
`ifndef PONG_SEVSEG_EN
        bad = bad || bus.an !== 4'hF || bus.seg !== 7'h7F;
`endif
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL %s: still/s1/s2/over/win got %b/%0d/%0d/%b/%b an=%h seg=%h, want %b/%0d/%0d/%b/%b",
                     name, act[10], act[9:6], act[5:2], act[1], act[0], bus.an, bus.seg,
                     exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic checkModel(input string name);
        checkOut(name, {mMode != 2, 4'(mS1), 4'(mS2), mMode == 4, mWin});
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; bus.start = 0; bus.frame_tick = 0; bus.hit1 = 0; bus.hit2 = 0;
        tbl.push_back('{5'b11000, 11'b1_0000_0000_0_0}); // reset, start held
        tbl.push_back('{5'b01000, 11'b1_0000_0000_0_0}); // held start is no press
        tbl.push_back('{5'b00000, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b01100, 11'b1_0000_0000_0_0}); // press; entry tick not counted
        tbl.push_back('{5'b01100, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b01100, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b00000, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b00100, 11'b0_0000_0000_0_0}); // third tick: play
        tbl.push_back('{5'b00000, 11'b0_0000_0000_0_0});
        tbl.push_back('{5'b00010, 11'b1_0000_0000_0_0}); // hit1: still next cycle
        tbl.push_back('{5'b00000, 11'b1_0000_0001_0_0}); // score2 one cycle later
        tbl.push_back('{5'b00110, 11'b1_0000_0001_0_0}); // hit1 in serve ignored
        tbl.push_back('{5'b00100, 11'b1_0000_0001_0_0});
        tbl.push_back('{5'b00100, 11'b0_0000_0001_0_0});
        tbl.push_back('{5'b00001, 11'b1_0000_0001_0_0});
        tbl.push_back('{5'b00000, 11'b1_0001_0001_0_0});
        tbl.push_back('{5'b00100, 11'b1_0001_0001_0_0});
        tbl.push_back('{5'b00100, 11'b1_0001_0001_0_0});
        tbl.push_back('{5'b00100, 11'b0_0001_0001_0_0});
        tbl.push_back('{5'b00001, 11'b1_0001_0001_0_0});
        tbl.push_back('{5'b00000, 11'b1_0010_0001_1_0}); // player 1 wins
        tbl.push_back('{5'b00001, 11'b1_0010_0001_1_0}); // hit2 in OVER ignored
        tbl.push_back('{5'b01000, 11'b1_0000_0000_0_0}); // restart clears
        tbl.push_back('{5'b01010, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b01100, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b01100, 11'b1_0000_0000_0_0});
        tbl.push_back('{5'b01100, 11'b0_0000_0000_0_0});
        tbl.push_back('{5'b00011, 11'b1_0000_0000_0_0}); // both hits: hit1 wins
        tbl.push_back('{5'b00000, 11'b1_0000_0001_0_0});
        tbl.push_back('{5'b00100, 11'b1_0000_0001_0_0});
        tbl.push_back('{5'b11111, 11'b1_0000_0000_0_0}); // reset mid-serve
        tbl.push_back('{5'b01000, 11'b1_0000_0000_0_0});

        foreach (tbl[i]) begin
            step(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            checkOut($sformatf("tbl%0d", i), tbl[i].exp);
        end

`ifdef PONG_SEVSEG_EN
        begin
            bit [3:0] seen;
            seen = '0;
            step(1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            for (int i = 0; i < SF; i++) step(0, 1, 1, 0, 0);
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
            checkModel("seg_setup");
            for (int i = 0; i < 20; i++) begin
                step(0, 0, 0, 0, 0);
                vectors++;
                if ($countones(~bus.an) != 1) begin
                    errors++;
                    $display("FAIL an_onecold: got %b, want exactly one low bit", bus.an);
                end
                for (int d = 0; d < 4; d++) if (!bus.an[d]) seen[d] = 1'b1;
                if (bus.an == 4'b1011) begin
                    vectors++;
                    if (bus.seg !== 7'b1111001) begin
                        errors++;
                        $display("FAIL seg_digit2: got %b, want 1111001", bus.seg);
                    end
                end
            end
            vectors++;
            if (seen != 4'hF) begin
                errors++;
                $display("FAIL an_scan: digits seen %b, want 1111", seen);
            end
        end
`endif

        step(1, 0, 0, 0, 0);
        checkModel("rnd_reset");
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
            checkModel($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pong_score_ctrl.md
# pong_score_ctrl

Game-flow and scoring controller for the pong design. Sits directly downstream of the pixel/ball stage: consumes its `hit1`/`hit2` miss indications, keeps both players' scores, and drives that stage's `still` input to park the ball at centre between points. Optionally drives a 4-digit seven-segment score display.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win; legal range 1..15.
- `SERVE_FRAMES`, 90: frames the ball is held still before each serve; legal range 1..255.
- `SCAN_DIV`, 16: scan-counter low-bit count for the seven-segment digit rate.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: start/restart button, level, pre-synchronised.
- `frame_tick` in 1: one-cycle pulse per video frame, from the VGA sync stage.
- `hit1` in 1: ball lost past paddle 1 (right side); point to player 2.
- `hit2` in 1: ball lost past paddle 2 (left side); point to player 1.
- `still` out 1: registered; 1 = hold ball at centre.
- `score1` out 4: player 1 score, binary.
- `score2` out 4: player 2 score, binary.
- `game_over` out 1: registered; 1 in OVER state.
- `winner` out 1: 0 = player 1, 1 = player 2; valid only when `game_over` = 1.
- `an` out 4: digit enables, active-low.
- `seg` out 7: segments a..g on `seg[0]`..`seg[6]`, active-low.

## Operation
- Reset values: state IDLE, `still` = 1, `score1` = `score2` = 0, `game_over` = 0, `winner` = 0, `an` = 4'hF, `seg` = 7'h7F, serve counter 0.
- `start` is rising-edge detected internally with a 1-bit history register, which resets to 1 so a button held through reset is not a press.
- IDLE: `still` = 1. A `start` rise moves to SERVE.
- SERVE: `still` = 1. The serve counter clears on entry and increments on each `frame_tick`. A `frame_tick` with counter == `SERVE_FRAMES`-1 moves to PLAY.
- PLAY: `still` = 0. `hit1` moves to POINT and credits player 2. Otherwise `hit2` moves to POINT and credits player 1. If both are high, `hit1` wins.
- POINT: lasts one cycle. The credited score increments by 1. If the new value == `WIN_SCORE`, the state moves to OVER and `winner` is set to the credited player; otherwise it returns to SERVE.
- OVER: `still` = 1, `game_over` = 1. A `start` rise clears both scores and `game_over` and moves to SERVE.
- `hit1`/`hit2` are ignored in every state except PLAY. `start` is ignored in SERVE, PLAY and POINT.
- Scores never exceed `WIN_SCORE`, so there is no wrap.

## Timing
- `still` and `game_over` are registered from the next-state value, so they change on the same edge the state changes.
- A `hit` sampled high in PLAY at edge N gives `still` = 1 after edge N. The score updates after edge N+1.
- Minimum serve time is `SERVE_FRAMES` whole `frame_tick` pulses counted after entering SERVE. A tick coinciding with the entry edge is not counted.
- `reset` in any state returns all outputs to their reset values on the next edge, regardless of other inputs.

## Configuration
- Macro: `PONG_SEVSEG_EN`.
- Defined:
  - A free-running scan counter of `SCAN_DIV`+2 bits; its top 2 bits select the digit.
  - Digits 3..0 show `score1` tens, `score1` ones, `score2` tens, `score2` ones, in decimal.
  - Exactly one `an` bit is low at a time.
  - `an`/`seg` are registered.
- Undefined: no scan logic is compiled; `an` = 4'hF and `seg` = 7'h7F constantly.
- Scoring behaviour is identical in both builds.

## Structure
- Shared package `pong_pkg`: state enum (IDLE, SERVE, PLAY, POINT, OVER), the seven-segment digit-to-pattern constant table, and the score width constant (4).
- Sub-module `pong_sevseg` holds the scan counter, binary-to-decimal split and segment decode. It is instantiated only under `PONG_SEVSEG_EN`.

## Test plan
All scenarios use `WIN_SCORE` = 2 and `SERVE_FRAMES` = 3 unless stated.
- Reset release with `start` held high: stays IDLE, `still` = 1. Release then press `start`: SERVE; exactly 3 `frame_tick` pulses later `still` = 0.
- In PLAY, pulse `hit1` for 1 cycle: `still` = 1 next cycle, `score2` = 1 one cycle later, `score1` = 0, back in SERVE.
- Two `hit2` points: `score1` = 2, `game_over` = 1, `winner` = 0, `still` = 1. Further `hit2` pulses leave `score1` = 2.
- In OVER, press `start`: scores = 0, `game_over` = 0, SERVE. `hit1` asserted during SERVE does not change `score2`.
- `hit1` and `hit2` high together in PLAY: only `score2` increments. Assert `reset` mid-SERVE: all outputs return to their reset values next edge.
- With `PONG_SEVSEG_EN` and `SCAN_DIV` = 2, `score1` = 1, `score2` = 0: `an` cycles through 4 one-cold values, and the digit-2 pattern is active-low "1" (7'b1111001).
